led_trail_fader: RTL and testbench
==================================

LED_TRAIL_FADER -- requirements
Module: led_trail_fader

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 10, number of LED outputs.
REQ-002 SHALL have parameter PWM_BITS, default 4, width of per-LED brightness and PWM counter.
REQ-003 SHALL have parameter DECAY, default 4, brightness subtracted from each non-head LED per Step.
REQ-004 SHALL have port Clock50  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Enable  input  1  run/blank control from the on/off toggle; 1 = run.
REQ-007 SHALL have port Step  input  1  single-cycle strobe; head position advanced this cycle.
REQ-008 SHALL have port Position  input  4  head LED index from the up/down counter; valid 0..NUM_LEDS-1.
REQ-009 SHALL have port LEDRArray  output  NUM_LEDS  registered PWM drive, bit i = LED i.
REQ-010 SHALL have port Active  output  1  registered; 1 when any brightness register is non-zero.

Function
REQ-011 SHALL hold one PWM_BITS-wide brightness register B[i] per LED, MAX = 2^PWM_BITS-1.
REQ-012 SHALL hold one free-running PWM_BITS-wide counter C, incrementing by 1 each cycle Enable=1, wrapping MAX->0.
REQ-013 SHALL, on a cycle with Step=1 and Enable=1, set B[Position] to MAX.
REQ-014 SHALL, on the same cycle, set every other B[i] to max(B[i]-DECAY, 0); saturating, no wrap.
REQ-015 SHALL, when Position >= NUM_LEDS with Step=1, set no head; all B[i] decay per REQ-014.
REQ-016 SHALL leave all B[i] unchanged on cycles with Step=0.
REQ-017 SHALL ignore Step and hold all B[i] and C while Enable=0.
REQ-018 SHALL register LEDRArray[i] = Enable & (B[i] > C), evaluated on the pre-edge B and C; one-cycle latency.
REQ-019 SHALL therefore give LED i a duty of B[i]/2^PWM_BITS over any 2^PWM_BITS consecutive enabled cycles; B=0 is never on.
REQ-020 SHALL drive LEDRArray to all zeros on the cycle after Enable falls; resume PWM from the held C on the cycle after Enable rises.
REQ-021 SHALL register Active = OR of all B[i] (pre-edge values), independent of Enable.
REQ-022 SHALL treat Step held high for N cycles as N separate steps.
REQ-023 SHALL give reset priority over Enable and Step on the same cycle.

Reset
REQ-024 SHALL, on a cycle with Reset=1, clear all B[i], C, LEDRArray and Active to 0 on that edge.
REQ-025 SHALL, on reset mid-operation, discard the trail fully; no brightness survives.
REQ-026 SHALL require no initial values beyond Reset for correct operation.

Verification
REQ-027 Reset, Enable=1, Step pulse with Position=3 -> B[3]=15; LEDRArray[3] high 15 of next 16 cycles, all other bits 0, Active=1.
REQ-028 Continue: Step with Position=4 -> B[4]=15, B[3]=11; LEDRArray[3] high 11 of 16 cycles; two further Steps at Position=5,6 -> B[3]=3; a fourth Step -> B[3]=0 (saturated), LED 3 dark.
REQ-029 After B[3]=15, Step with Position=12 -> no head set, B[3]=11; after four such Steps all B=0 and Active=0 on the following cycle.
REQ-030 Enable dropped mid-trail -> LEDRArray=0 next cycle, Step pulses ignored, B and C held; Enable restored -> same duty pattern resumes from held C.
REQ-031 Reset asserted with Step=1, Enable=1, Position=2 -> next cycle all B=0, C=0, LEDRArray=0, Active=0.
REQ-032 Sweep Position 0..9..0 with Step every 8 cycles -> head LED always duty 15/16, tail LEDs duty 11/16, 7/16, 3/16 behind head, no bit outside 0..9 ever set.

Source files
------------

// File: rtl/led_trail_fader_if.sv
// Control and display signals between the position/step logic and the LED trail fader.
interface led_trail_fader_if #(
    parameter int NUM_LEDS = 10
);
    logic                Enable;
    logic                Step;
    logic [3:0]          Position;
    logic [NUM_LEDS-1:0] LEDRArray;
    logic                Active;

    // The controller side drives run/step/head and watches the LED drive.
    modport master (
        output Enable,
        output Step,
        output Position,
        input  LEDRArray,
        input  Active
    );

    // The fader receives run/step/head and produces the LED drive.
    modport slave (
        input  Enable,
        input  Step,
        input  Position,
        output LEDRArray,
        output Active
    );
endinterface

// File: rtl/led_trail_fader.sv
// LED trail fader: the head LED is lit at full brightness on each step.
// Every other LED loses DECAY brightness per step, which leaves a fading trail.
// Brightness is rendered by comparing each level against a shared free-running PWM counter.
module led_trail_fader #(
    parameter int NUM_LEDS = 10,
    parameter int PWM_BITS = 4,
    parameter int DECAY    = 4
) (
    input logic              Clock50,
    input logic              Reset,
    led_trail_fader_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

    logic [PWM_BITS-1:0] bright [NUM_LEDS];
    logic [PWM_BITS-1:0] next_bright [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_count;
    logic [NUM_LEDS-1:0] pwm_on;
    logic                any_lit;

    // Brightness each LED takes on a step. The head goes to full brightness.
    // The others decay with saturation at zero. An out-of-range head matches no LED.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            next_bright[i] = '0;
            if (int'(bus.Position) == i) begin
                next_bright[i] = MAX_LEVEL;
            end else if (int'(bright[i]) > DECAY) begin
                next_bright[i] = bright[i] - PWM_BITS'(DECAY);
            end
        end
    end

    // PWM comparison per LED, and an OR over all levels so an idle trail can be detected.
    always_comb begin
        pwm_on  = '0;
        any_lit = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm_on[i] = (bright[i] > pwm_count);
            any_lit   = any_lit | (bright[i] != '0);
        end
    end

    // Trail state. While disabled, both the counter and the levels freeze so the pattern can resume intact.
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            pwm_count <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright[i] <= '0;
            end
        end else if (bus.Enable) begin
            pwm_count <= pwm_count + PWM_BITS'(1);
            if (bus.Step) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    bright[i] <= next_bright[i];
                end
            end
        end
    end

    // Registered outputs. The LEDs are blanked while disabled. Active ignores Enable.
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            bus.LEDRArray <= '0;
            bus.Active    <= 1'b0;
        end else begin
            bus.LEDRArray <= bus.Enable ? pwm_on : '0;
            bus.Active    <= any_lit;
        end
    end
endmodule

// File: tb/tb_led_trail_fader.sv
// Scoreboard bench for led_trail_fader.
// The stimulus side pushes per-cycle expectations from a behavioural model and hand-computed duty counts.
// The monitor pops and compares these after every clock edge.
module tb_led_trail_fader;
    localparam int NUM_LEDS = 10;

    typedef struct {
        int                  cyc;
        bit                  is_duty;
        logic [NUM_LEDS-1:0] led;
        logic                active;
        int                  idx;
        int                  count;
    } sb_entry_t;

    logic clock50;
    logic reset;

    led_trail_fader_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_trail_fader #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(4),
        .DECAY(4)
    ) dut (
        .Clock50(clock50),
        .Reset(reset),
        .bus(bus)
    );

    sb_entry_t           scoreboard[$];
    sb_entry_t           mon_entry;
    logic [NUM_LEDS-1:0] history [16];
    int                  cycle_count = 0;
    int                  check_count = 0;
    int                  pass_count  = 0;
    int                  model_bright [NUM_LEDS];
    int                  model_count = 0;

    // 50 MHz-style free-running clock
    initial clock50 = 1'b0;
    always #5 clock50 = ~clock50;

    // Drive one cycle of inputs on the falling edge, queue the expected outputs after the next rising edge, then advance the model.
    task automatic applyStimulus(input logic rst, input logic en, input logic st, input int pos);
        sb_entry_t e;
        @(negedge clock50);
        reset        = rst;
        bus.Enable   = en;
        bus.Step     = st;
        bus.Position = 4'(pos);
        e.cyc     = cycle_count + 1;
        e.is_duty = 1'b0;
        e.idx     = 0;
        e.count   = 0;
        e.active  = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            e.led[i] = !rst && en && (model_bright[i] > model_count);
            if (!rst && model_bright[i] != 0) e.active = 1'b1;
        end
        scoreboard.push_back(e);
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) model_bright[i] = 0;
            model_count = 0;
        end else if (en) begin
            if (st) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (pos == i) model_bright[i] = 15;
                    else model_bright[i] = (model_bright[i] - 4 < 0) ? 0 : model_bright[i] - 4;
                end
            end
            model_count = (model_count + 1) % 16;
        end
    endtask

    // Queue a hand-computed on-count for one LED. The count covers the 16 samples ending at the next edge.
    task automatic checkOutput(input int idx, input int count);
        sb_entry_t e;
        e.cyc     = cycle_count + 1;
        e.is_duty = 1'b1;
        e.led     = '0;
        e.active  = 1'b0;
        e.idx     = idx;
        e.count   = count;
        scoreboard.push_back(e);
    endtask

    // Enabled cycles with no step, so the brightness levels hold still.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: sample just after each rising edge and retire every expectation due on this cycle.
    always @(posedge clock50) begin
        cycle_count = cycle_count + 1;
        #1;
        history[cycle_count % 16] = bus.LEDRArray;
        while (scoreboard.size() != 0 && scoreboard[0].cyc <= cycle_count) begin
            mon_entry = scoreboard.pop_front();
            if (mon_entry.is_duty) begin
                int n;
                n = 0;
                for (int k = 0; k < 16; k++) if (history[k][mon_entry.idx]) n++;
                check_count++;
                if (n == mon_entry.count) pass_count++;
                else $display("[TB] FAIL duty led%0d cyc=%0d actual=%0d/16 required=%0d/16",
                              mon_entry.idx, cycle_count, n, mon_entry.count);
            end else begin
                check_count++;
                if (bus.LEDRArray === mon_entry.led) pass_count++;
                else $display("[TB] FAIL ledr cyc=%0d actual=%b required=%b",
                              cycle_count, bus.LEDRArray, mon_entry.led);
                check_count++;
                if (bus.Active === mon_entry.active) pass_count++;
                else $display("[TB] FAIL active cyc=%0d actual=%b required=%b",
                              cycle_count, bus.Active, mon_entry.active);
            end
        end
    end

    // Directed scenarios
    initial begin
        int wait_cycles;
        reset        = 1'b1;
        bus.Enable   = 1'b0;
        bus.Step     = 1'b0;
        bus.Position = 4'd0;
        for (int i = 0; i < NUM_LEDS; i++) model_bright[i] = 0;
        for (int k = 0; k < 16; k++) history[k] = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);

        $display("[TB] single head and decay chain");
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        idleCycles(16);
        checkOutput(3, 15);
        checkOutput(4, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4);
        idleCycles(16);
        checkOutput(3, 11);
        checkOutput(4, 15);
        applyStimulus(1'b0, 1'b1, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 6);
        idleCycles(16);
        checkOutput(3, 3);
        checkOutput(4, 7);
        checkOutput(5, 11);
        checkOutput(6, 15);
        applyStimulus(1'b0, 1'b1, 1'b1, 7);
        idleCycles(16);
        checkOutput(3, 0);
        checkOutput(6, 11);
        checkOutput(7, 15);

        $display("[TB] out-of-range head");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 12);
        idleCycles(16);
        checkOutput(3, 11);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, 12);
        idleCycles(3);

        $display("[TB] enable dropped mid-trail");
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        idleCycles(5);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, k[0], 5);
        idleCycles(16);
        checkOutput(3, 15);
        checkOutput(5, 0);

        $display("[TB] reset with step pending");
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        idleCycles(2);

        $display("[TB] position sweep");
        for (int p = 0; p < 19; p++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, (p < 10) ? p : 18 - p);
            idleCycles(7);
        end
        idleCycles(3);

        wait_cycles = 0;
        while (scoreboard.size() != 0 && wait_cycles < 10) begin
            @(posedge clock50);
            wait_cycles++;
        end
        #2;
        if (scoreboard.size() != 0) begin
            check_count++;
            $display("[TB] FAIL drain pending=%0d required=0", scoreboard.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
